// File: rtl/mf_pkg.sv
// Shared types and constants for the salt-and-pepper mean filter controller.
package mf_pkg;

    localparam int DW_DEFAULT      = 8;
    localparam int FB_INIT_DEFAULT = 128;

    localparam logic [DW_DEFAULT-1:0] PIX_MIN = '0;
    localparam logic [DW_DEFAULT-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SUBST,
        MEAN,
        OUT
    } state_e;

    // Width-generic noise test: callers zero-extend the pixel and pass their own width.
    function automatic logic is_noisy(input logic [31:0] pix, input int unsigned dw);
        logic [31:0] max_v;
        max_v = (32'd1 << dw) - 32'd1;
        return (pix == 32'd0) || (pix == max_v);
    endfunction

endpackage

// File: rtl/mf_window_ctrl_if.sv
// Window-in / pixel-out handshake bundle for mf_window_ctrl.
interface mf_window_ctrl_if #(
    parameter int DW = mf_pkg::DW_DEFAULT
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] p_c;
    logic [DW-1:0] p0;
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;
    logic [DW-1:0] p3;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] p_out;
    logic          out_repl;
    logic          out_fb;
    logic          busy;

    modport master (
        output in_valid, p_c, p0, p1, p2, p3, out_ready,
        input  in_ready, out_valid, p_out, out_repl, out_fb, busy
    );

    modport slave (
        input  in_valid, p_c, p0, p1, p2, p3, out_ready,
        output in_ready, out_valid, p_out, out_repl, out_fb, busy
    );

endinterface

// File: rtl/Detector.sv
// Single-pixel salt-and-pepper detector: flags the extreme codes 0 and 2^DW-1.
module Detector
    import mf_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] pix,
    output logic          noisy
);

    assign noisy = is_noisy(32'(pix), DW);

endmodule

// File: rtl/csg.sv
// Neighbour clean-set gate: ctr is high only when all four neighbours are clean.
module csg
    import mf_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    output logic          ctr
);

    assign ctr = !(is_noisy(32'(p0), DW) || is_noisy(32'(p1), DW) ||
                   is_noisy(32'(p2), DW) || is_noisy(32'(p3), DW));

endmodule

// File: rtl/mf_mean4.sv
// Combinational mean of four pixels. Build option MF_MEAN_ROUND_EN rounds half up,
// otherwise the quotient is truncated.
module mf_mean4 #(
    parameter int DW = mf_pkg::DW_DEFAULT
) (
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    output logic [DW-1:0] mean
);

    logic [DW:0]   sum_a;
    logic [DW:0]   sum_b;
    logic [DW+1:0] sum;

    assign sum_a = (DW+1)'(p0) + (DW+1)'(p1);
    assign sum_b = (DW+1)'(p2) + (DW+1)'(p3);
    assign sum   = (DW+2)'(sum_a) + (DW+2)'(sum_b);

`ifdef MF_MEAN_ROUND_EN
    // Clean inputs keep sum+2 well below 2^(DW+2), so the add cannot wrap.
    assign mean = DW'((sum + (DW+2)'(2)) >> 2);
`else
    assign mean = DW'(sum >> 2);
`endif

endmodule

// File: rtl/mf_window_ctrl.sv
// Salt-and-pepper mean filter sequencer: pass-through, neighbour mean, or mean after
// feedback substitution. Owns the feedback pixel register. Option: MF_MEAN_ROUND_EN.
module mf_window_ctrl
    import mf_pkg::*;
#(
    parameter int            DW      = DW_DEFAULT,
    parameter logic [DW-1:0] FB_INIT = DW'(FB_INIT_DEFAULT)
) (
    input logic             clk,
    input logic             rst,
    mf_window_ctrl_if.slave bus
);

    state_e        state;
    state_e        state_nxt;
    logic [DW-1:0] c_q;
    logic [DW-1:0] nb_q [4];
    logic [DW-1:0] fb_q;
    logic [DW-1:0] p_out_q;
    logic [DW-1:0] mean;
    logic          fb_flag_q;
    logic          repl_q;
    logic          fbo_q;
    logic          c_noisy;
    logic          nb_clean;
    logic          accept;

    assign accept = (state == IDLE) && bus.in_valid;

    Detector #(.DW(DW)) u_det_c (.pix(c_q), .noisy(c_noisy));

    csg #(.DW(DW)) u_csg (
        .p0 (nb_q[0]),
        .p1 (nb_q[1]),
        .p2 (nb_q[2]),
        .p3 (nb_q[3]),
        .ctr(nb_clean)
    );

    mf_mean4 #(.DW(DW)) u_mean (
        .p0  (nb_q[0]),
        .p1  (nb_q[1]),
        .p2  (nb_q[2]),
        .p3  (nb_q[3]),
        .mean(mean)
    );

    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (!c_noisy)      state_nxt = OUT;
                else if (nb_clean) state_nxt = MEAN;
                else               state_nxt = SUBST;
            end
            SUBST: state_nxt = MEAN;
            MEAN:  state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: window registers carry no reset; they are always written on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            c_q     <= bus.p_c;
            nb_q[0] <= bus.p0;
            nb_q[1] <= bus.p1;
            nb_q[2] <= bus.p2;
            nb_q[3] <= bus.p3;
        end else if (state == SUBST) begin
            for (int i = 0; i < 4; i++) begin
                if (is_noisy(32'(nb_q[i]), DW)) nb_q[i] <= fb_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_q      <= FB_INIT;
            fb_flag_q <= 1'b0;
            p_out_q   <= '0;
            repl_q    <= 1'b0;
            fbo_q     <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (!c_noisy) begin
                        p_out_q <= c_q;
                        repl_q  <= 1'b0;
                        fbo_q   <= 1'b0;
                    end
                end
                SUBST: fb_flag_q <= 1'b1;
                MEAN: begin
                    p_out_q <= mean;
                    repl_q  <= 1'b1;
                    fbo_q   <= fb_flag_q;
                end
                OUT: begin
                    // Emitted pixels are always clean, so the feedback stays clean too.
                    if (bus.out_ready) begin
                        fb_q      <= p_out_q;
                        fb_flag_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p_out    = p_out_q;
    assign bus.out_repl = repl_q;
    assign bus.out_fb   = fbo_q;

endmodule
